alu_exec_unit: RTL

//  Execution-side consumer of the 3-bit ALUControl code from the ALU decoder. Takes operands

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_shift_iter.sv | 39 +++
 rtl/alu_exec_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUControl code table and exec-unit FSM state encodings
package alu_pkg;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_XOR = 3'b100;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;
  localparam logic [2:0] ALUCTL_SLL = 3'b110;
  localparam logic [2:0] ALUCTL_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shifter with down-counter and last-step flag
module alu_shift_iter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             left,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] shifted,
  output logic             done
);

  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    count_q;
  logic             left_q;

  assign shifted = left_q ? (data_q << 1) : (data_q >> 1);
  // done marks the cycle whose shift is the final one, so the caller can capture shifted directly
  assign done    = (count_q == SW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
      left_q  <= 1'b0;
    end else if (load) begin
      data_q  <= data_in;
      count_q <= shamt;
      left_q  <= left;
    end else if (count_q != '0) begin
      data_q  <= shifted;
      count_q <= count_q - SW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked ALU execute stage; iterative SLL/SRL under ALU_EXEC_SHIFT_EN
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);
  import alu_pkg::*;

  alu_state_e       state, state_next;
  logic [WIDTH-1:0] result_q, res_next, alu_out;
  logic             zero_q, load_res;

`ifdef ALU_EXEC_SHIFT_EN
  localparam int SW = $clog2(WIDTH);
  logic             is_shift, shift_load, shift_done;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] shifted;

  assign is_shift = (ALUControl == ALUCTL_SLL) || (ALUControl == ALUCTL_SRL);
  assign shamt    = SrcB[SW-1:0];

  alu_shift_iter #(.WIDTH(WIDTH), .SW(SW)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (shift_load),
    .left    (ALUControl == ALUCTL_SLL),
    .data_in (SrcA),
    .shamt   (shamt),
    .shifted (shifted),
    .done    (shift_done)
  );
`endif

  always_comb begin
    alu_out = '0;
    case (ALUControl)
      ALUCTL_ADD: alu_out = SrcA + SrcB;
      ALUCTL_SUB: alu_out = SrcA - SrcB;
      ALUCTL_AND: alu_out = SrcA & SrcB;
      ALUCTL_OR:  alu_out = SrcA | SrcB;
      ALUCTL_XOR: alu_out = SrcA ^ SrcB;
      ALUCTL_SLT: alu_out = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      default:    alu_out = '0;
    endcase
  end

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

  always_comb begin
    state_next = state;
    load_res   = 1'b0;
    res_next   = alu_out;
`ifdef ALU_EXEC_SHIFT_EN
    shift_load = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (in_valid && in_ready) begin
          load_res   = 1'b1;
          state_next = ST_DONE;
`ifdef ALU_EXEC_SHIFT_EN
          if (is_shift) begin
            if (shamt == '0) begin
              res_next = SrcA;
            end else begin
              load_res   = 1'b0;
              shift_load = 1'b1;
              state_next = ST_SHIFT;
            end
          end
`endif
        end else if ((state == ST_DONE) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
`ifdef ALU_EXEC_SHIFT_EN
      ST_SHIFT: begin
        if (shift_done) begin
          load_res   = 1'b1;
          res_next   = shifted;
          state_next = ST_DONE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (load_res) begin
        result_q <= res_next;
        zero_q   <= (res_next == '0);
      end
    end
  end

endmodule
